// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer. in_sel picks one of two independent FIFOs.
// Each output has its own delivered-beat counter.
module demux1to2_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q [2];
  logic [AW:0]       wptr_d [2];
  logic [AW:0]       rptr_q [2];
  logic [AW:0]       rptr_d [2];
  logic [WIDTH-1:0]  mem_q  [2][DEPTH];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  cnt_d  [2];
  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        out_rdy;

  assign out_rdy = {out1_ready, out0_ready};

  // in_ready depends only on FIFO state, so a full FIFO stays closed even
  // when the same cycle pops it.
  always_comb begin
    full     = '0;
    empty    = '0;
    push     = '0;
    pop      = '0;
    in_ready = 1'b0;
    for (int unsigned n = 0; n < 2; n++) begin
      full[n]  = (wptr_q[n][AW-1:0] == rptr_q[n][AW-1:0]) &&
                 (wptr_q[n][AW] != rptr_q[n][AW]);
      empty[n] = (wptr_q[n] == rptr_q[n]);
    end
    in_ready = ~full[in_sel];
    for (int unsigned n = 0; n < 2; n++) begin
      push[n]   = in_valid && in_ready && (in_sel == 1'(n));
      pop[n]    = !empty[n] && out_rdy[n];
      wptr_d[n] = wptr_q[n] + {{AW{1'b0}}, push[n]};
      rptr_d[n] = rptr_q[n] + {{AW{1'b0}}, pop[n]};
      cnt_d[n]  = cnt_q[n] + {{(CNT_W-1){1'b0}}, pop[n]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < 2; n++) begin
        wptr_q[n] <= '0;
        rptr_q[n] <= '0;
        cnt_q[n]  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[n][i] <= '0;
        end
      end
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        if (push[n]) begin
          mem_q[n][wptr_q[n][AW-1:0]] <= in_data;
        end
        wptr_q[n] <= wptr_d[n];
        rptr_q[n] <= rptr_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
    end
  end

  assign out0_valid = !empty[0];
  assign out1_valid = !empty[1];
  assign out0_data  = mem_q[0][rptr_q[0][AW-1:0]];
  assign out1_data  = mem_q[1][rptr_q[1][AW-1:0]];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule
